// File: rtl/r_response_memory.sv
// Per-uid R beat reorder store: beats are parked per unique id and released in order for one selected uid.
// Optional beat occupancy counter output enabled by defining RM_OCCUPANCY_EN.
module r_response_memory #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter int MAX_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_store_valid,
  output logic                  r_store_ready,
  input  logic [ID_WIDTH-1:0]   r_store_id,
  input  logic [DATA_WIDTH-1:0] r_store_data,
  input  logic [RESP_WIDTH-1:0] r_store_resp,
  input  logic                  r_store_last,
  input  logic [ID_WIDTH-1:0]   rm_release_uid,
  output logic                  r_release_valid,
  input  logic                  r_release_ready,
  output logic [DATA_WIDTH-1:0] r_release_data,
  output logic [RESP_WIDTH-1:0] r_release_resp,
  output logic                  r_release_last,
  output logic                  overflow_err
`ifdef RM_OCCUPANCY_EN
  ,output logic [$clog2((2**ID_WIDTH)*MAX_LEN+1)-1:0] rm_occupancy
`endif
);
  localparam int NUM_SLOTS = 2**ID_WIDTH;
  localparam int CNT_W     = $clog2(MAX_LEN) + 1;
  localparam int PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [DATA_WIDTH-1:0] mem_data [NUM_SLOTS][MAX_LEN];
  logic [RESP_WIDTH-1:0] mem_resp [NUM_SLOTS][MAX_LEN];
  logic                  mem_last [NUM_SLOTS][MAX_LEN];

  logic [PTR_W-1:0] wr_ptr [NUM_SLOTS];
  logic [PTR_W-1:0] rd_ptr [NUM_SLOTS];
  logic [CNT_W-1:0] count  [NUM_SLOTS];
  logic             closed [NUM_SLOTS];

  logic st_hs, rel_hs, rel_free;
  logic [DATA_WIDTH-1:0] head_data;
  logic [RESP_WIDTH-1:0] head_resp;
  logic                  head_last;

  assign head_data = mem_data[rm_release_uid][rd_ptr[rm_release_uid]];
  assign head_resp = mem_resp[rm_release_uid][rd_ptr[rm_release_uid]];
  assign head_last = mem_last[rm_release_uid][rd_ptr[rm_release_uid]];

  assign r_release_valid = (count[rm_release_uid] != '0);
  assign r_release_data  = r_release_valid ? head_data : '0;
  assign r_release_resp  = r_release_valid ? head_resp : '0;
  assign r_release_last  = r_release_valid & head_last;

  assign rel_hs   = r_release_valid & r_release_ready;
  assign rel_free = rel_hs & head_last;

  // A slot draining its last beat is being freed, so it must not take a new beat in the same cycle.
  assign r_store_ready = ~closed[r_store_id] & (count[r_store_id] < CNT_W'(MAX_LEN))
                       & ~(rel_free & (rm_release_uid == r_store_id));
  assign st_hs = r_store_valid & r_store_ready;

  always_ff @(posedge clk) begin
    if (st_hs) begin
      mem_data[r_store_id][wr_ptr[r_store_id]] <= r_store_data;
      mem_resp[r_store_id][wr_ptr[r_store_id]] <= r_store_resp;
      mem_last[r_store_id][wr_ptr[r_store_id]] <= r_store_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
        closed[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (rel_free && rm_release_uid == ID_WIDTH'(s)) begin
          wr_ptr[s] <= '0;
          rd_ptr[s] <= '0;
          count[s]  <= '0;
          closed[s] <= 1'b0;
        end else begin
          if (st_hs && r_store_id == ID_WIDTH'(s)) begin
            wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
            if (r_store_last) closed[s] <= 1'b1;
          end
          if (rel_hs && rm_release_uid == ID_WIDTH'(s))
            rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
          count[s] <= count[s] + CNT_W'(st_hs && r_store_id == ID_WIDTH'(s))
                               - CNT_W'(rel_hs && rm_release_uid == ID_WIDTH'(s));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow_err <= 1'b0;
    else if (r_store_valid && count[r_store_id] == CNT_W'(MAX_LEN) && !closed[r_store_id])
      overflow_err <= 1'b1;
  end

`ifdef RM_OCCUPANCY_EN
  localparam int OCC_W = $clog2(NUM_SLOTS*MAX_LEN+1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rm_occupancy <= '0;
    else     rm_occupancy <= rm_occupancy + OCC_W'(st_hs) - OCC_W'(rel_hs);
  end
`endif
endmodule

// File: tb/tb_r_response_memory.sv
// Randomized + directed bench for r_response_memory with per-uid queue reference model and scoreboard monitor.
module tb_r_response_memory;
  localparam int IW = 4, DW = 32, RW = 2, ML = 8, NS = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic [RW-1:0] resp;
    logic          last;
  } beat_t;

  logic clk = 0, rst = 1;
  logic sv = 0, sl = 0, rr = 0;
  logic [IW-1:0] sid = 0, ruid = 0;
  logic [DW-1:0] sd = 0;
  logic [RW-1:0] srs = 0;
  logic s_ready, r_valid, r_last, ovf;
  logic [DW-1:0] r_data;
  logic [RW-1:0] r_resp;
`ifdef RM_OCCUPANCY_EN
  logic [$clog2(NS*ML+1)-1:0] occ;
`endif

  int errors = 0, checks = 0;

  r_response_memory #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst),
    .r_store_valid(sv), .r_store_ready(s_ready), .r_store_id(sid),
    .r_store_data(sd), .r_store_resp(srs), .r_store_last(sl),
    .rm_release_uid(ruid),
    .r_release_valid(r_valid), .r_release_ready(rr),
    .r_release_data(r_data), .r_release_resp(r_resp), .r_release_last(r_last),
    .overflow_err(ovf)
`ifdef RM_OCCUPANCY_EN
    ,.rm_occupancy(occ)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each uid is a FIFO of beats plus a "burst terminated" flag.
  beat_t mq [NS][$];
  bit    m_closed [NS];
  bit    m_ovf;

  function automatic bit exp_ready();
    bit freeing;
    freeing = rr && mq[ruid].size() != 0 && mq[ruid][0].last && ruid == sid;
    return !m_closed[sid] && mq[sid].size() < ML && !freeing;
  endfunction

  function automatic int total_beats();
    int t = 0;
    for (int i = 0; i < NS; i++) t += mq[i].size();
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        mq[i].delete();
        m_closed[i] = 0;
      end
      m_ovf = 0;
    end else begin
      bit sh, rh;
      beat_t b, nb;
      sh = sv && exp_ready();
      rh = rr && mq[ruid].size() != 0;
      if (sv && mq[sid].size() == ML && !m_closed[sid]) m_ovf = 1;
      if (rh) begin
        b = mq[ruid].pop_front();
        if (b.last) begin
          m_closed[ruid] = 0;
          mq[ruid].delete();
        end
      end
      if (sh) begin
        nb.data = sd; nb.resp = srs; nb.last = sl;
        mq[sid].push_back(nb);
        if (sl) m_closed[sid] = 1;
      end
    end
  end

  // Monitor: compares every presented output against the model, away from the active edge.
  always @(negedge clk) begin
    #2;
    chk("store_ready", 64'(s_ready), 64'(exp_ready()));
    chk("rel_valid", 64'(r_valid), 64'(mq[ruid].size() != 0));
    if (mq[ruid].size() != 0)
      chk("rel_beat", {29'd0, r_data, r_resp, r_last},
          {29'd0, mq[ruid][0].data, mq[ruid][0].resp, mq[ruid][0].last});
    else
      chk("rel_idle_zero", {29'd0, r_data, r_resp, r_last}, 64'd0);
    chk("overflow_err", 64'(ovf), 64'(m_ovf));
`ifdef RM_OCCUPANCY_EN
    chk("occupancy", 64'(occ), 64'(total_beats()));
`endif
  end

  task automatic cyc(input bit v, input int id, input logic [DW-1:0] d, input bit l,
                     input int ru, input bit r);
    @(negedge clk);
    sv = v; sid = IW'(id); sd = d; srs = d[RW-1:0]; sl = l;
    ruid = IW'(ru); rr = r;
    @(posedge clk);
  endtask

  task automatic idle(input int ru);
    cyc(0, 0, 0, 0, ru, 0);
  endtask

  initial begin
    #12;
    @(negedge clk);
    chk("reset_valid", 64'(r_valid), 64'd0);
    chk("reset_ready", 64'(s_ready), 64'd1);
    chk("reset_ovf", 64'(ovf), 64'd0);
    rst = 0;

    // Three-beat burst on uid 5, drained in order.
    cyc(1, 5, 32'hA, 0, 5, 0);
    cyc(1, 5, 32'hB, 0, 5, 0);
    cyc(1, 5, 32'hC, 1, 5, 0);
    repeat (3) cyc(0, 0, 0, 0, 5, 1);
    idle(5);

    // Interleaved uids 3 and 7, released out of order.
    cyc(1, 3, 32'h31, 0, 7, 0);
    cyc(1, 3, 32'h32, 1, 7, 0);
    cyc(1, 7, 32'h71, 1, 7, 0);
    cyc(0, 0, 0, 0, 7, 1);
    idle(3);
    repeat (2) cyc(0, 0, 0, 0, 3, 1);
    idle(3);

    // Streaming: store last beat while the first one leaves.
    cyc(1, 4, 32'h40, 0, 4, 0);
    cyc(1, 4, 32'h41, 1, 4, 1);
    cyc(0, 0, 0, 0, 4, 1);
    idle(4);

    // Last-beat release blocks a same-cycle store to that uid; accepted next cycle.
    cyc(1, 6, 32'h60, 1, 6, 0);
    @(negedge clk);
    sv = 1; sid = 6; sd = 32'h61; srs = 1; sl = 1; ruid = 6; rr = 1;
    #1 chk("free_blocks_store", 64'(s_ready), 64'd0);
    @(posedge clk);
    cyc(1, 6, 32'h61, 1, 6, 0);
    cyc(0, 0, 0, 0, 6, 1);
    idle(6);

    // Reset in the middle of a burst.
    cyc(1, 1, 32'h10, 0, 1, 0);
    cyc(1, 1, 32'h11, 0, 1, 0);
    @(negedge clk);
    sv = 0; sid = 1; rr = 0; ruid = 1;
    #3 rst = 1;
    #1 chk("midrst_valid", 64'(r_valid), 64'd0);
    chk("midrst_ready", 64'(s_ready), 64'd1);
`ifdef RM_OCCUPANCY_EN
    chk("midrst_occ", 64'(occ), 64'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    cyc(1, 1, 32'h1A, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    idle(1);

    // Fill uid 2 without last, then push one more.
    for (int i = 0; i < ML; i++) cyc(1, 2, 32'h200 + i, 0, 2, 0);
    @(negedge clk);
    sv = 1; sid = 2; sd = 32'h2FF; sl = 0; rr = 0;
    #1 chk("full_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    idle(2);
    idle(2);
    @(negedge clk) #1 chk("ovf_sticky", 64'(ovf), 64'd1);

    @(negedge clk) rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;

    // Random traffic over a few uids.
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3), $urandom_range(0, 1));
    idle(0);
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
